inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Fetch stage between the PC/redirect logic and decode. Drives line addresses into
//  InstMemory, captures the returned 128-bit lines and buffers up to two of them.
//  Unpacks each line into four 32-bit instructions with their PCs and hands them to
//  decode over a valid/ready handshake. Redirects (branch/jump) flush everything
//  in flight.
// PARAMETERS
//  RESET_PC   32'h0000_0000  byte PC fetched after reset; bits[1:0] ignored
//  BUF_LINES  2              line-buffer depth; fixed at 2, other values unsupported
// PORTS
//  CLk             in   1    single clock, rising edge
//  rst_n           in   1    asynchronous, active-low reset
//  mem_addr        out  32   line address to InstMemory = {4'b0, pc[31:4]}; registered
//  mem_req         out  1    mem_addr in this cycle is a real request; its data is captured
//  mem_line        in   128  line from InstMemory, valid the cycle after mem_addr is sampled
//  redirect_valid  in   1    replace fetch PC with redirect_pc; flush
//  redirect_pc     in   32   new byte PC (bits[1:0] ignored)
//  inst_valid      out  1    inst_word/inst_pc valid to decode
//  inst_ready      in   1    decode accepts; transfer when valid & ready
//  inst_word       out  32   instruction
//  inst_pc         out  32   byte PC of inst_word
// BEHAVIOUR
//  Reset (async, takes effect immediately):
//   - mem_addr = RESET_PC[31:4]; mem_req = 0; inst_valid = 0.
//   - inst_word = 0; inst_pc = RESET_PC.
//   - Buffer empty; fetch PC = RESET_PC; request pipeline cleared.
//  Memory timing:
//   - InstMemory is a registered read.
//   - A request issued at edge t (mem_addr/mem_req update) returns mem_line after edge t+1.
//   - The line is captured into the buffer at edge t+2 if the tag pipe (mem_req -> req_d1) is still set.
//  Issue rule:
//   - At each edge, issue the next line when occupancy + mem_req + req_d1 < BUF_LINES.
//   - A pop in the same cycle is not credited (conservative).
//   - Otherwise mem_req = 0 and mem_addr holds its value.
//   - The next line address is the previous line address + 1, modulo 2^28.
//  Line layout:
//   - word k = mem_line[32k+31:32k]; word 0 is the lowest PC.
//   - Entry = {line, line_base_pc, start_word}.
//   - start_word = pc[3:2] for the first line after reset/redirect; 0 otherwise.
//  Output:
//   - The head entry drives word[ptr] with inst_pc = line_base_pc + 4*ptr.
//   - inst_valid = head present.
//   - While valid & !ready, inst_word and inst_pc are held stable.
//   - On transfer, ptr++. At ptr==3 the entry pops and ptr loads the next entry's start_word.
//  Throughput:
//   - One instruction per cycle sustained, no bubbles at line boundaries.
//   - inst_pc wraps 0xFFFF_FFFC -> 0x0000_0000.
//  Redirect (highest priority, sampled at edge t):
//   - A transfer completing in the same cycle counts as delivered.
//   - Buffer cleared; mem_req/req_d1 tags cleared, so any line arriving after t or t+1 is discarded.
//   - inst_valid = 0 after edge t.
//   - mem_addr = redirect_pc[31:4] with mem_req = 1 after t; line returns after t+1;
//     inst_valid = 1 after t+2, with word redirect_pc[3:2] and inst_pc = redirect_pc & ~3.
//   - Back-to-back redirects: the last one wins.
//  Boundaries:
//   - Buffer full: no issue.
//   - Buffer empty: inst_valid = 0.
//   - Capture and pop in the same cycle are both performed.
// STRUCTURE
//  - Shared package fetch_pkg holds: LINE_BITS=128, WORD_BITS=32, LINE_WORDS=4,
//    PC_OFFS_BITS=4, and the line-entry typedef {line, base_pc, start_word}.
//  - One sub-module: fetch_line_fifo, a 2-entry FIFO with flush, push, pop,
//    and full/empty/count outputs.
// TESTING
//  1. RESET_PC=0, lines preloaded, inst_ready=1, release rst_n ->
//     inst_valid first high after the 3rd edge; pc 0,4,8,C then 10,14... with no bubble.
//  2. inst_ready=0 for 6 cycles mid-line -> inst_word/inst_pc stable;
//     mem_req stops after 2 lines buffered/in flight; resumes with no words lost.
//  3. Redirect to 0x0000_0028 while streaming line 0 ->
//     next word is line 2 word 2 with pc 0x28, 3 edges later; no stale word appears.
//  4. Redirect in the same cycle as a returning line and a valid&ready transfer ->
//     the transferred word counts; the returning line is dropped; the next pc is the redirect target.
//  5. Redirect to 0xFFFF_FFF8 -> pcs FFFF_FFF8, FFFF_FFFC, then 0x0 with mem_addr 0x0.
//  6. Assert rst_n=0 between edges mid-stream ->
//     inst_valid and mem_req go 0 immediately; restart from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage: line/word geometry and
// the line-buffer entry layout used by inst_fetch_unit and fetch_line_fifo.
// No ports.
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int LINE_BITS    = 128;
  localparam int WORD_BITS    = 32;
  localparam int LINE_WORDS   = 4;
  localparam int PC_OFFS_BITS = 4;
  localparam int LADDR_BITS   = 32 - PC_OFFS_BITS;

  // One buffered fetch line. start_word is the first word to hand to decode
  // (non-zero only for the first line after reset or a redirect).
  typedef struct packed {
    logic [LINE_BITS-1:0] line;
    logic [31:0]          base_pc;
    logic [1:0]           start_word;
  } line_entry_t;

  // Word k of a line sits at bits [32k+31:32k]; word 0 has the lowest PC.
  function automatic logic [WORD_BITS-1:0] line_word(
    input logic [LINE_BITS-1:0] line,
    input logic [1:0]           idx
  );
    logic [WORD_BITS-1:0] w;
    case (idx)
      2'd0:    w = line[31:0];
      2'd1:    w = line[63:32];
      2'd2:    w = line[95:64];
      default: w = line[127:96];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/fetch_line_fifo.sv
// ---------------------------------------------------------------------------
// fetch_line_fifo
// Two-entry line buffer. The head entry always lives in slot 0 so the reader
// never needs a read pointer. Push and pop in the same cycle are both done;
// flush empties the buffer and wins over push/pop.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush_i       drop all entries
//   push_i        write push_data_i (ignored when full without a pop)
//   pop_i         remove the head entry (ignored when empty)
//   push_data_i   entry to write
//   head_o        current head entry (meaningful when !empty_o)
//   next_sw_o     start_word of the entry behind the head
//   empty_o       no entries
//   full_o        two entries
//   count_o       number of entries (0..2)
// ---------------------------------------------------------------------------
module fetch_line_fifo
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  line_entry_t push_data_i,
  output line_entry_t head_o,
  output logic [1:0]  next_sw_o,
  output logic        empty_o,
  output logic        full_o,
  output logic [1:0]  count_o
);

  line_entry_t slot0_q, slot0_d;
  line_entry_t slot1_q, slot1_d;
  logic [1:0]  count_q, count_d;
  logic        push_eff;
  logic        pop_eff;

  assign empty_o   = (count_q == 2'd0);
  assign full_o    = (count_q == 2'd2);
  assign count_o   = count_q;
  assign head_o    = slot0_q;
  assign next_sw_o = slot1_q.start_word;

  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_eff);

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_eff, pop_eff})
        2'b11: begin
          if (count_q == 2'd1) begin
            slot0_d = push_data_i;
          end else begin
            slot0_d = slot1_q;
            slot1_d = push_data_i;
          end
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) slot0_d = push_data_i;
          else                 slot1_d = push_data_i;
          count_d = count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 2'd0;
    else        count_q <= count_d;
  end

  // Payload is qualified by count_q, so it needs no reset.
  always_ff @(posedge clk) begin
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
// Fetch stage: issues line addresses to a registered-read instruction memory,
// buffers up to BUF_LINES returned lines and streams their words to decode
// over a valid/ready handshake. A redirect flushes everything in flight.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   mem_addr        line address {4'b0, pc[31:4]} (registered)
//   mem_req         mem_addr is a real request this cycle
//   mem_line        128-bit line, valid the cycle after mem_addr is sampled
//   redirect_valid  restart fetch at redirect_pc, flushing in-flight work
//   redirect_pc     new byte PC (bits [1:0] ignored)
//   inst_valid      inst_word/inst_pc valid
//   inst_ready      decode accepts (transfer on valid & ready)
//   inst_word       instruction
//   inst_pc         byte PC of inst_word
// ---------------------------------------------------------------------------
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_LINES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [31:0]          mem_addr,
  output logic                 mem_req,
  input  logic [LINE_BITS-1:0] mem_line,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [31:0]          inst_word,
  output logic [31:0]          inst_pc
);

  // Request stage: address currently presented to memory and its tag.
  logic [LADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_req_q, mem_req_d;
  logic [1:0]            sw_q, sw_d;
  // Next line to issue and the start word it would carry.
  logic [LADDR_BITS-1:0] next_line_q, next_line_d;
  logic [1:0]            next_sw_q, next_sw_d;
  // Data-return stage: tag that travels with the line memory is returning.
  logic [LADDR_BITS-1:0] addr_d1_q, addr_d1_d;
  logic                  req_d1_q, req_d1_d;
  logic [1:0]            sw_d1_q, sw_d1_d;
  // Output side: word pointer into the head line, and the PC shown when idle.
  logic [1:0]            ptr_q, ptr_d;
  logic [31:0]           idle_pc_q, idle_pc_d;

  line_entry_t head_entry;
  line_entry_t push_entry;
  logic [1:0]  fifo_next_sw;
  logic        fifo_empty;
  logic        fifo_full;
  logic [1:0]  fifo_count;

  logic        issue;
  logic        xfer;
  logic        pop;
  logic        push;
  logic [31:0] head_pc;
  logic [31:0] head_word;
  logic        unused_bits;

  assign unused_bits = ^{redirect_pc[1:0], head_entry.start_word};

  // Lines still in flight are counted as occupied; a pop in this same cycle
  // is deliberately not credited.
  assign issue = !fifo_full &&
                 ((int'(fifo_count) + int'(mem_req_q) + int'(req_d1_q)) < BUF_LINES);
  assign xfer  = inst_valid && inst_ready;
  assign pop   = xfer && (ptr_q == 2'(LINE_WORDS - 1));
  assign push  = req_d1_q && !redirect_valid;

  assign push_entry.line       = mem_line;
  assign push_entry.base_pc    = {addr_d1_q, {PC_OFFS_BITS{1'b0}}};
  assign push_entry.start_word = sw_d1_q;

  fetch_line_fifo u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (push_entry),
    .head_o      (head_entry),
    .next_sw_o   (fifo_next_sw),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  assign head_word = line_word(head_entry.line, ptr_q);
  assign head_pc   = head_entry.base_pc + {28'd0, ptr_q, 2'b00};

  assign inst_valid = !fifo_empty;
  assign inst_word  = fifo_empty ? 32'd0 : head_word;
  assign inst_pc    = fifo_empty ? idle_pc_q : head_pc;
  assign mem_addr   = {{PC_OFFS_BITS{1'b0}}, mem_addr_q};
  assign mem_req    = mem_req_q;

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_req_d   = 1'b0;
    sw_d        = sw_q;
    next_line_d = next_line_q;
    next_sw_d   = next_sw_q;
    if (redirect_valid) begin
      mem_addr_d  = redirect_pc[31:PC_OFFS_BITS];
      mem_req_d   = 1'b1;
      sw_d        = redirect_pc[3:2];
      next_line_d = redirect_pc[31:PC_OFFS_BITS] + 28'd1;
      next_sw_d   = 2'd0;
    end else if (issue) begin
      mem_addr_d  = next_line_q;
      mem_req_d   = 1'b1;
      sw_d        = next_sw_q;
      next_line_d = next_line_q + 28'd1;
      next_sw_d   = 2'd0;
    end
  end

  // Clearing the return tag on redirect drops whatever line is on its way.
  always_comb begin
    addr_d1_d = mem_addr_q;
    sw_d1_d   = sw_q;
    req_d1_d  = mem_req_q && !redirect_valid;
  end

  always_comb begin
    ptr_d     = ptr_q;
    idle_pc_d = idle_pc_q;
    if (redirect_valid) begin
      ptr_d     = 2'd0;
      idle_pc_d = {redirect_pc[31:2], 2'b00};
    end else begin
      if (xfer) idle_pc_d = inst_pc + 32'd4;
      if (pop) begin
        // Next head is the second slot, or the line landing this very edge.
        if (fifo_count == 2'd2) ptr_d = fifo_next_sw;
        else if (push)          ptr_d = sw_d1_q;
        else                    ptr_d = 2'd0;
      end else if (xfer) begin
        ptr_d = ptr_q + 2'd1;
      end else if (fifo_empty && push) begin
        ptr_d = sw_d1_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q  <= RESET_PC[31:PC_OFFS_BITS];
      mem_req_q   <= 1'b0;
      sw_q        <= 2'd0;
      next_line_q <= RESET_PC[31:PC_OFFS_BITS];
      next_sw_q   <= RESET_PC[3:2];
      addr_d1_q   <= '0;
      req_d1_q    <= 1'b0;
      sw_d1_q     <= 2'd0;
      ptr_q       <= 2'd0;
      idle_pc_q   <= {RESET_PC[31:2], 2'b00};
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      sw_q        <= sw_d;
      next_line_q <= next_line_d;
      next_sw_q   <= next_sw_d;
      addr_d1_q   <= addr_d1_d;
      req_d1_q    <= req_d1_d;
      sw_d1_q     <= sw_d1_d;
      ptr_q       <= ptr_d;
      idle_pc_q   <= idle_pc_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit
// Directed bench for inst_fetch_unit with an instruction-stream model: decode
// must see consecutive PCs from the start/redirect target, each word equal to
// the memory image word at that PC, and requests must walk consecutive lines.
// ---------------------------------------------------------------------------
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  mem_addr;
  logic         mem_req;
  logic [127:0] mem_line = '0;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         inst_valid;
  logic         inst_ready;
  logic [31:0]  inst_word;
  logic [31:0]  inst_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .BUF_LINES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_req        (mem_req),
    .mem_line       (mem_line),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_word      (inst_word),
    .inst_pc        (inst_pc)
  );

  // Memory image: the word at byte PC p is p ^ C0DE_0001.
  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0001;
  endfunction

  function automatic logic [127:0] line_of(input logic [27:0] la);
    return {word_of({la, 4'hC}), word_of({la, 4'h8}),
            word_of({la, 4'h4}), word_of({la, 4'h0})};
  endfunction

  // Registered-read instruction memory.
  always @(posedge clk) mem_line <= line_of(mem_addr[27:0]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream model, evaluated on every falling edge.
  initial begin
    logic [31:0] exp_pc;
    logic [27:0] exp_line;
    bit          need_req;
    exp_pc   = RESET_PC & 32'hFFFF_FFFC;
    exp_line = RESET_PC[31:4];
    need_req = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        exp_pc   = RESET_PC & 32'hFFFF_FFFC;
        exp_line = RESET_PC[31:4];
        need_req = 0;
      end else begin
        if (need_req) chk("redirect_req", 32'(mem_req), 32'd1);
        need_req = 0;
        if (mem_req) begin
          chk("req_addr", mem_addr, {4'b0, exp_line});
          exp_line = exp_line + 28'd1;
        end
        if (inst_valid) begin
          chk("stream_pc", inst_pc, exp_pc);
          chk("stream_word", inst_word, word_of(exp_pc));
          if (inst_ready) exp_pc = exp_pc + 32'd4;
        end
        if (redirect_valid) begin
          exp_pc   = redirect_pc & 32'hFFFF_FFFC;
          exp_line = redirect_pc[31:4];
          need_req = 1;
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    #2;
    chk("reset_valid", 32'(inst_valid), 32'd0);
    chk("reset_req", 32'(mem_req), 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_word", inst_word, 32'd0);
    chk("reset_pc", inst_pc, 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Startup latency and gapless streaming.
    step();
    chk("t1_req1", 32'(mem_req), 32'd1);
    chk("t1_addr1", mem_addr, 32'd0);
    chk("t1_valid1", 32'(inst_valid), 32'd0);
    step();
    chk("t1_addr2", mem_addr, 32'd1);
    chk("t1_valid2", 32'(inst_valid), 32'd0);
    step();
    chk("t1_valid3", 32'(inst_valid), 32'd1);
    chk("t1_pc0", inst_pc, 32'h0000_0000);
    chk("t1_word0", inst_word, 32'hC0DE_0001);
    repeat (4) step();
    chk("t1_pc10", inst_pc, 32'h0000_0010);
    chk("t1_word10", inst_word, 32'hC0DE_0011);

    // Mid-line stall: output held, fetch throttled, then resume.
    repeat (2) step();
    chk("t2_pc18", inst_pc, 32'h0000_0018);
    inst_ready = 1'b0;
    repeat (6) step();
    chk("t2_hold_valid", 32'(inst_valid), 32'd1);
    chk("t2_hold_pc", inst_pc, 32'h0000_0018);
    chk("t2_hold_word", inst_word, 32'hC0DE_0019);
    chk("t2_req_stopped", 32'(mem_req), 32'd0);
    inst_ready = 1'b1;
    repeat (2) step();
    chk("t2_resume_pc", inst_pc, 32'h0000_0020);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid_async", 32'(inst_valid), 32'd0);
    chk("t6_req_async", 32'(mem_req), 32'd0);
    chk("t6_addr_async", mem_addr, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("t6_restart_valid", 32'(inst_valid), 32'd1);
    chk("t6_restart_pc", inst_pc, 32'h0000_0000);

    // Redirect while streaming line 0.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0028;
    step();
    redirect_valid = 1'b0;
    chk("t3_flush_valid", 32'(inst_valid), 32'd0);
    step();
    chk("t3_gap_valid", 32'(inst_valid), 32'd0);
    step();
    chk("t3_valid", 32'(inst_valid), 32'd1);
    chk("t3_pc28", inst_pc, 32'h0000_0028);
    chk("t3_word28", inst_word, 32'hC0DE_0029);

    // Redirect coinciding with a returning line and a transfer.
    repeat (4) step();
    chk("t4_pre_pc", inst_pc, 32'h0000_0038);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0107;
    step();
    redirect_valid = 1'b0;
    chk("t4_flush_valid", 32'(inst_valid), 32'd0);
    chk("t4_req", 32'(mem_req), 32'd1);
    chk("t4_addr", mem_addr, 32'h0000_0010);
    step();
    chk("t4_gap_valid", 32'(inst_valid), 32'd0);
    step();
    chk("t4_pc104", inst_pc, 32'h0000_0104);
    chk("t4_word104", inst_word, 32'hC0DE_0105);

    // Irregular ready pattern.
    for (int i = 0; i < 9; i++) begin
      inst_ready = (i % 3) != 2;
      step();
    end
    inst_ready = 1'b1;

    // Back-to-back redirects: the second wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_pc    = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    chk("b2b_valid0", 32'(inst_valid), 32'd0);
    step();
    chk("b2b_valid1", 32'(inst_valid), 32'd0);
    step();
    chk("b2b_pc300", inst_pc, 32'h0000_0300);
    chk("b2b_word300", inst_word, 32'hC0DE_0301);
    repeat (3) step();

    // Redirect near the top of the address space: PC wraps to 0.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    chk("t5_addr_top", mem_addr, 32'h0FFF_FFFF);
    chk("t5_req_top", 32'(mem_req), 32'd1);
    step();
    chk("t5_addr_wrap", mem_addr, 32'h0000_0000);
    chk("t5_req_wrap", 32'(mem_req), 32'd1);
    step();
    chk("t5_pcF8", inst_pc, 32'hFFFF_FFF8);
    chk("t5_wordF8", inst_word, 32'h3F21_FFF9);
    step();
    chk("t5_pcFC", inst_pc, 32'hFFFF_FFFC);
    chk("t5_wordFC", inst_word, 32'h3F21_FFFD);
    step();
    chk("t5_pc0", inst_pc, 32'h0000_0000);
    chk("t5_word0", inst_word, 32'hC0DE_0001);
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
